pwm_fade_ctrl: RTL and testbench
================================

Name: pwm_fade_ctrl

Overview:
Duty-cycle sequencer for a single PWM channel, driving the team's free-running 15-bit counter/compare PWM core. Accepts target duty codes over a valid/ready handshake and ramps the live duty one code at a time. Each step takes effect every STEP_PERIODS PWM periods. Duty changes are applied only at the counter wrap, so no period is ever truncated or glitched. Sits between the switch/CSR front-end and the LED PWM output.

Parameters:
CBITS, 15, PWM counter width; one period = 2**CBITS clocks
DBITS, 4, duty code width
STEP_PERIODS, 4, PWM periods between successive duty steps (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
tgt_duty  in  DBITS  requested duty code
tgt_valid  in  1  request valid
tgt_ready  out  1  high only in IDLE
cur_duty  out  DBITS  duty code currently being ramped toward target
pwm_out  out  1  registered PWM pulse
period_end  out  1  one-cycle pulse when counter == 2**CBITS-1
busy  out  1  high in RAMP_UP / RAMP_DOWN

Behaviour:
- Reset (async, rst=1): cnt=0, cur_duty=0, active_duty=0, step_cnt=0, target=0, pwm_out=0, state=IDLE. tgt_ready=1 and busy=0 whenever rst=1.
- Threshold: thresh(d) = {1'b0, d, 1'b1, (CBITS-DBITS-2)'b0}, so duty is never 0% or 100%. Duty 0 gives 2**(CBITS-DBITS-2) high clocks per period.
- Counter: cnt increments every clock and wraps 2**CBITS-1 -> 0. period_end is combinational (cnt == max).
- pwm_out <= (cnt < thresh(active_duty)), registered, 1-cycle latency.
- active_duty <= cur_duty_next, only on the edge where period_end=1. The new value is used from cnt=0 onward.
- FSM IDLE:
  - On tgt_valid && tgt_ready: latch target and clear step_cnt.
  - target > cur_duty -> RAMP_UP.
  - target < cur_duty -> RAMP_DOWN.
  - target == cur_duty -> stay IDLE; the request is consumed with no change.
- FSM RAMP_UP / RAMP_DOWN, on each period_end:
  - If step_cnt == STEP_PERIODS-1: step_cnt <= 0 and cur_duty +/-= 1. If the new cur_duty == target, go to IDLE.
  - Otherwise step_cnt += 1.
- The period_end of the accept cycle itself is not counted. The first step therefore lands on the STEP_PERIODS-th later period_end.
- cur_duty_next includes that edge's step, so the step shows on pwm_out in the very next period.
- tgt_valid while busy: not accepted. The requester holds it, and it is accepted on the first IDLE cycle.
- Arithmetic: cur_duty never wraps. Stepping stops exactly at target, which is inside 0..2**DBITS-1 by construction.
- Reset asserted mid-ramp: all state returns to reset values immediately, and the target in flight is discarded.
- Invariant (assertable), from the second clock after reset onward:
  - pwm_out implies the previous cnt < thresh(2**DBITS-1).
  - The previous cnt < thresh(0) implies pwm_out.

Decomposition:
- Shared package pwm_pkg holds:
  - default CBITS/DBITS constants
  - the state enum {IDLE, RAMP_UP, RAMP_DOWN}
  - function thresh(d)
- One sub-module, pwm_core: counter, period_end, shadowed active_duty load, compare and pwm_out register. Inputs are cur_duty_next and a load strobe.
- The FSM and step counter stay in pwm_fade_ctrl.

Test Plan (CBITS=6, DBITS=2, STEP_PERIODS=2, period=64, thresh = 4/12/20/28):
- Reset released, no requests -> pwm_out high exactly 4 of every 64 clocks; cur_duty=0; tgt_ready=1; busy=0; period_end every 64th clock.
- In IDLE, tgt_duty=3 with tgt_valid for 1 cycle -> accepted.
  - busy=1 and tgt_ready=0 from the next cycle.
  - cur_duty=1, 2, 3 at the 2nd, 4th and 6th following period_end.
  - pwm_out high time 4,4,12,12,20,20,28 per period; IDLE after the 6th period_end.
- From duty 3, request 0 -> symmetric ramp down 28 -> 20 -> 12 -> 4 with the same step spacing; busy falls with cur_duty=0.
- Request equal to cur_duty (2 while at 2) -> tgt_ready=1 on the accept cycle; state stays IDLE; busy never asserts; pwm_out unchanged.
- tgt_valid held with tgt_duty=1 during a ramp toward 3 -> not accepted until busy drops. Then accepted, and the ramp down from 3 to 1 follows.
- rst pulsed mid-ramp at cnt=30 -> pwm_out=0, cur_duty=0, tgt_ready=1 immediately (async). After release the counter restarts at 0 with 4-clock pulses.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM fade controller and its counter/compare core.
package pwm_pkg;

  localparam int unsigned CBITS_DEF = 15;
  localparam int unsigned DBITS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN
  } state_e;

  // Compare threshold {0, d, 1, zeros}: the forced top-0/low-1 bits keep duty off 0% and 100%.
  function automatic logic [31:0] thresh(input logic [31:0] d,
                                         input int unsigned cbits,
                                         input int unsigned dbits);
    return ((d << 1) | 32'd1) << (cbits - dbits - 2);
  endfunction

endpackage

// File: rtl/pwm_core.sv
// Free-running counter/compare PWM core with a duty shadow register loaded at the counter wrap.
module pwm_core
  import pwm_pkg::*;
#(
  parameter int unsigned CBITS = CBITS_DEF,
  parameter int unsigned DBITS = DBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DBITS-1:0] duty_i,
  input  logic             load_i,
  output logic             period_end_o,
  output logic             pwm_o
);

  logic [CBITS-1:0] cnt_q;
  logic [CBITS-1:0] thr;
  logic [DBITS-1:0] active_duty_q;
  logic             pwm_q;

  assign thr          = CBITS'(thresh(32'(active_duty_q), CBITS, DBITS));
  assign period_end_o = (cnt_q == '1);
  assign pwm_o        = pwm_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      active_duty_q <= '0;
      pwm_q         <= 1'b0;
    end else begin
      cnt_q <= cnt_q + CBITS'(1);
      pwm_q <= (cnt_q < thr);
      // Loading only on the wrap edge means the new duty starts cleanly at cnt=0.
      if (load_i) active_duty_q <= duty_i;
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle sequencer: accepts a target duty code and ramps one code per STEP_PERIODS PWM periods.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned CBITS        = CBITS_DEF,
  parameter int unsigned DBITS        = DBITS_DEF,
  parameter int unsigned STEP_PERIODS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DBITS-1:0] tgt_duty_i,
  input  logic             tgt_valid_i,
  output logic             tgt_ready_o,
  output logic [DBITS-1:0] cur_duty_o,
  output logic             pwm_out_o,
  output logic             period_end_o,
  output logic             busy_o
);

  localparam int unsigned     SBITS     = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [SBITS-1:0] STEP_LAST = SBITS'(STEP_PERIODS - 1);

  state_e           state_q;
  logic [DBITS-1:0] target_q;
  logic [DBITS-1:0] cur_duty_q;
  logic [DBITS-1:0] cur_duty_d;
  logic [SBITS-1:0] step_cnt_q;
  logic             period_end;
  logic             step_now;

  // The core shadows cur_duty_d at the wrap, so a step taken on this edge shows next period.
  always_comb begin
    step_now   = (state_q != IDLE) && period_end && (step_cnt_q == STEP_LAST);
    cur_duty_d = cur_duty_q;
    if (step_now) begin
      if (state_q == RAMP_UP) cur_duty_d = cur_duty_q + DBITS'(1);
      else                    cur_duty_d = cur_duty_q - DBITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      target_q   <= '0;
      cur_duty_q <= '0;
      step_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tgt_valid_i) begin
            target_q   <= tgt_duty_i;
            step_cnt_q <= '0;
            if (tgt_duty_i > cur_duty_q)      state_q <= RAMP_UP;
            else if (tgt_duty_i < cur_duty_q) state_q <= RAMP_DOWN;
          end
        end
        RAMP_UP, RAMP_DOWN: begin
          if (period_end) begin
            if (step_now) begin
              step_cnt_q <= '0;
              cur_duty_q <= cur_duty_d;
              if (cur_duty_d == target_q) state_q <= IDLE;
            end else begin
              step_cnt_q <= step_cnt_q + SBITS'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tgt_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign cur_duty_o  = cur_duty_q;

  pwm_core #(
    .CBITS(CBITS),
    .DBITS(DBITS)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .duty_i      (cur_duty_d),
    .load_i      (period_end),
    .period_end_o(period_end),
    .pwm_o       (pwm_out_o)
  );

  assign period_end_o = period_end;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl: per-period high time, duty and busy checked at each wrap.
module tb_pwm_fade_ctrl;

  localparam int CBITS  = 6;
  localparam int DBITS  = 2;
  localparam int STEP   = 2;
  localparam int PERIOD = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DBITS-1:0] tgt_duty = '0;
  logic             tgt_valid = 1'b0;
  logic             tgt_ready;
  logic [DBITS-1:0] cur_duty;
  logic             pwm_out;
  logic             period_end;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int hi;
    int cur;
    int busy;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   hi_acc  = 0;
  int   cyc_acc = 0;
  bit   seen_pe = 1'b0;

  pwm_fade_ctrl #(
    .CBITS       (CBITS),
    .DBITS       (DBITS),
    .STEP_PERIODS(STEP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tgt_duty_i  (tgt_duty),
    .tgt_valid_i (tgt_valid),
    .tgt_ready_o (tgt_ready),
    .cur_duty_o  (cur_duty),
    .pwm_out_o   (pwm_out),
    .period_end_o(period_end),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int thr(input int d);
    return 8 * d + 4;
  endfunction

  function automatic void push(input int hi, input int cur, input int bsy);
    exp_t e;
    e.hi   = hi;
    e.cur  = cur;
    e.busy = bsy;
    sb_q.push_back(e);
  endfunction

  // Every code from 'from' up to (not including) 'to' is held STEP periods, counting the accept period.
  function automatic void push_ramp(input int from, input int to, input bit fin);
    int d   = from;
    int dir = (to > from) ? 1 : -1;
    while (d != to) begin
      for (int s = 0; s < STEP; s++) push(thr(d), d, 1);
      d += dir;
    end
    if (fin) push(thr(to), to, 0);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      hi_acc  = 0;
      cyc_acc = 0;
      seen_pe = 1'b0;
    end else begin
      cyc_acc++;
      hi_acc += int'(pwm_out);
      if (period_end) begin
        if (seen_pe) check("period_len", cyc_acc, PERIOD);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check("hi_time", hi_acc, mon_e.hi);
          check("pe_cur_duty", 32'(cur_duty), mon_e.cur);
          check("pe_busy", 32'(busy), mon_e.busy);
        end
        hi_acc  = 0;
        cyc_acc = 0;
        seen_pe = 1'b1;
      end
    end
  end

  task automatic wait_pe();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_end && n < 4 * PERIOD);
    check("pe_seen", 32'(period_end), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 * PERIOD && sb_q.size() > 0; i++) @(negedge clk);
    check("drain_empty", sb_q.size(), 0);
  endtask

  // Issue a one-cycle request early in a period so the accept never lands on a wrap.
  task automatic request(input int d);
    wait_pe();
    @(negedge clk);
    @(negedge clk);
    tgt_duty  = DBITS'(d);
    tgt_valid = 1'b1;
    check("ready_before_accept", 32'(tgt_ready), 1);
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  initial begin
    int bsy;
    int n;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(tgt_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_cur", 32'(cur_duty), 0);
    check("rst_pe", 32'(period_end), 0);
    push(thr(0), 0, 0);
    push(thr(0), 0, 0);
    rst = 1'b0;
    drain();

    request(3);
    check("up_busy", 32'(busy), 1);
    check("up_ready", 32'(tgt_ready), 0);
    push_ramp(0, 3, 1'b1);
    drain();

    request(0);
    check("down_busy", 32'(busy), 1);
    push_ramp(3, 0, 1'b1);
    drain();

    request(2);
    push_ramp(0, 2, 1'b1);
    drain();

    request(2);
    check("eq_busy", 32'(busy), 0);
    check("eq_ready", 32'(tgt_ready), 1);
    push(thr(2), 2, 0);
    bsy = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      bsy |= int'(busy);
    end
    check("eq_busy_never", bsy, 0);
    drain();

    // Request 3, then hold a request for 1 while the ramp is still running.
    wait_pe();
    @(negedge clk);
    @(negedge clk);
    tgt_duty  = 2'd3;
    tgt_valid = 1'b1;
    @(negedge clk);
    check("hold_busy", 32'(busy), 1);
    push_ramp(2, 3, 1'b0);
    push_ramp(3, 1, 1'b1);
    tgt_duty = 2'd1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tgt_ready && n < 20 * PERIOD);
    check("hold_ready", 32'(tgt_ready), 1);
    check("hold_cur_at_release", 32'(cur_duty), 3);
    @(negedge clk);
    tgt_valid = 1'b0;
    check("hold_accepted", 32'(busy), 1);
    drain();

    // Reset in the middle of a ramp from 1 toward 3, at cnt=30.
    request(3);
    wait_pe();
    wait_pe();
    wait_pe();
    repeat (31) @(negedge clk);
    check("mid_cur", 32'(cur_duty), 2);
    check("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("arst_pwm", 32'(pwm_out), 0);
    check("arst_cur", 32'(cur_duty), 0);
    check("arst_ready", 32'(tgt_ready), 1);
    check("arst_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push(thr(0), 0, 0);
    push(thr(0), 0, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
